// File: rtl/alu_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: funct codes, FSM states,
// 1-bit slice operation select and small decode helpers.
package alu_serial_ctrl_pkg;

  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_SLT = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SLICE_AND  = 2'd0,
    SLICE_OR   = 2'd1,
    SLICE_ADD  = 2'd2,
    SLICE_LESS = 2'd3
  } slice_op_t;

  // SLT runs through the adder; the compare is resolved once the word is done.
  function automatic slice_op_t op_sel(input logic [5:0] funct);
    case (funct)
      FUNCT_AND: op_sel = SLICE_AND;
      FUNCT_OR:  op_sel = SLICE_OR;
      default:   op_sel = SLICE_ADD;
    endcase
  endfunction

  function automatic logic is_sub(input logic [5:0] funct);
    is_sub = (funct == FUNCT_SUB) || (funct == FUNCT_SLT);
  endfunction

  // Unknown codes behave as ADD, so they report overflow too.
  function automatic logic reports_ovf(input logic [5:0] funct);
    reports_ovf = !((funct == FUNCT_AND) || (funct == FUNCT_OR) || (funct == FUNCT_SLT));
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_alu_1bit.sv
// One-bit ALU slice: AND / OR / full-add with optional B inversion / Less pass-through.
module alu_serial_ctrl_alu_1bit
  import alu_serial_ctrl_pkg::*;
(
  input  logic      a,
  input  logic      b,
  input  logic      cin,
  input  logic      invert_b,
  input  logic      less,
  input  slice_op_t op,
  output logic      res,
  output logic      cout
);

  logic bb, sum;

  assign bb   = b ^ invert_b;
  assign sum  = a ^ bb ^ cin;
  assign cout = (a & bb) | (cin & (a ^ bb));

  always_comb begin
    res = 1'b0;
    case (op)
      SLICE_AND:  res = a & bb;
      SLICE_OR:   res = a | bb;
      SLICE_ADD:  res = sum;
      SLICE_LESS: res = less;
      default:    res = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one word op per WIDTH+3 cycles through a single 1-bit
// slice, LSB first, with carry held between bits and flags fixed up at the end.
module alu_serial_ctrl
  import alu_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [5:0]       funct_q;
  logic             carry, inv_b, c_in_msb;
  logic [CW-1:0]    cnt;
  logic             last_bit, s_res, s_cout, ovf;
  logic [WIDTH-1:0] fix_result;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  alu_serial_ctrl_alu_1bit u_slice (
    .a        (a_sr[0]),
    .b        (b_sr[0]),
    .cin      (carry),
    .invert_b (inv_b),
    .less     (1'b0),
    .op       (op_sel(funct_q)),
    .res      (s_res),
    .cout     (s_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // After the last RUN shift, res_sr[WIDTH-1] holds the sum MSB and carry the final cout.
  always_comb begin
    ovf        = c_in_msb ^ carry;
    fix_result = res_sr;
    if (funct_q == FUNCT_SLT)
      fix_result = {{(WIDTH-1){1'b0}}, res_sr[WIDTH-1] ^ ovf};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      funct_q  <= '0;
      carry    <= 1'b0;
      inv_b    <= 1'b0;
      c_in_msb <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a_sr    <= dataA;
          b_sr    <= dataB;
          funct_q <= Signal;
          cnt     <= '0;
          carry   <= is_sub(Signal);
          inv_b   <= is_sub(Signal);
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {s_res, res_sr[WIDTH-1:1]};
          carry  <= s_cout;
          cnt    <= cnt + CW'(1);
          if (last_bit) c_in_msb <= carry;
        end
        ST_FIX: begin
          result   <= fix_result;
          zero     <= (fix_result == '0);
          overflow <= reports_ovf(funct_q) & ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Randomized self-checking bench for alu_serial_ctrl against a word-level arithmetic model.
module tb_alu_serial_ctrl;

  localparam int W = 32;
  localparam logic [5:0] F_AND = 6'd36, F_OR = 6'd37, F_ADD = 6'd32,
                         F_SUB = 6'd34, F_SLT = 6'd42;

  logic         clk, rst, start, busy, done, zero, overflow;
  logic [5:0]   sig;
  logic [W-1:0] data_a, data_b, result;

  int n_cmp = 0;
  int n_err = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .Signal(sig),
    .dataA(data_a), .dataB(data_b), .busy(busy), .done(done),
    .result(result), .zero(zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word-level reference: plain two's-complement arithmetic.
  function automatic void model(input logic [5:0] f, input logic [W-1:0] a, b,
                                output logic [W-1:0] r, output logic o);
    o = 1'b0;
    case (f)
      F_AND: r = a & b;
      F_OR:  r = a | b;
      F_SUB: begin
        r = a - b;
        o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      F_SLT: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: begin
        r = a + b;
        o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
    endcase
  endfunction

  // Issue one op, optionally pulse start again at edge count pulse_at, check everything.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a, b,
                        input int pulse_at);
    logic [W-1:0] er;
    logic         eo;
    int           lat;
    bit           seen;
    model(f, a, b, er, eo);
    @(negedge clk);
    start = 1'b1; sig = f; data_a = a; data_b = b;
    @(posedge clk); #1;
    lat = 1;
    chk({tag, " busy"}, busy, 1);
    seen = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      start  = (lat == pulse_at);
      sig    = 6'($urandom);
      data_a = $urandom;
      data_b = $urandom;
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk({tag, " lat"}, lat, W + 2);
    chk({tag, " result"}, result, er);
    chk({tag, " zero"}, zero, (er == '0));
    chk({tag, " ovf"}, overflow, eo);
    chk({tag, " busy_done"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, " pulse"}, done, 0);
    chk({tag, " held"}, result, er);
  endtask

  initial begin
    logic [W-1:0] er, ra, rb;
    logic         eo, seen;
    logic [5:0]   f;
    int           e, n, last_e;
    logic [W-1:0] corners [6];

    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001};
    rst = 1'b1; start = 1'b0; sig = '0; data_a = '0; data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst zero", zero, 0);
    chk("rst ovf", overflow, 0);
    @(negedge clk) rst = 1'b0;

    run_op("add", F_ADD, 32'h5, 32'h3, 0);
    run_op("sub_ovf", F_SUB, 32'h8000_0000, 32'h1, 0);
    run_op("sub_zero", F_SUB, 32'h1234, 32'h1234, 0);
    run_op("slt_neg", F_SLT, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("slt_ovf", F_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    run_op("and", F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op("or", F_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);

    // Async reset mid-RUN while result holds a nonzero value.
    @(negedge clk);
    start = 1'b1; sig = F_ADD; data_a = 32'h5; data_b = 32'h3;
    @(negedge clk) start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst result", result, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst ovf", overflow, 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    @(negedge clk) rst = 1'b0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("arst no_done", seen, 0);
    run_op("after_rst", F_ADD, 32'h7FFF_FFFF, 32'h1, 0);

    // Start pulse mid-RUN is ignored.
    run_op("mid_start", F_SUB, 32'h0000_0010, 32'h0000_0020, 12);

    // Start held high: one op every W+3 cycles.
    model(F_ADD, 32'hDEAD_0000, 32'h0000_BEEF, er, eo);
    @(negedge clk);
    start = 1'b1; sig = F_ADD; data_a = 32'hDEAD_0000; data_b = 32'h0000_BEEF;
    e = 0; n = 0; last_e = 0;
    while (n < 3 && e < 300) begin
      @(posedge clk); #1;
      e++;
      if (done) begin
        n++;
        chk("held result", result, er);
        if (n > 1) chk("held period", e - last_e, W + 3);
        last_e = e;
      end
    end
    chk("held count", n, 3);
    @(negedge clk) start = 1'b0;

    // Random ops, biased toward sign/carry corners, with some unknown codes.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: f = F_AND;
        1: f = F_OR;
        2: f = F_ADD;
        3: f = F_SUB;
        4: f = F_SLT;
        default: f = 6'($urandom);
      endcase
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 9) == 0) rb = ra;
      run_op($sformatf("rnd%0d f=%0d", i, f), f, ra, rb, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
